// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 write-back demultiplexer.
package demux_pkg;

  // Select encoding for in_sel.
  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

  // Width of the optional per-port completed-transfer counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO used as the per-destination queue of demux_1x8_reg.
// DEPTH must be a power of two so the pointers wrap naturally.
// Storage is cleared on reset so an idle port presents zero data.
module demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // A push into a full queue or a pop from an empty one is ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Payload storage: write the pushed beat at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Read/write pointers advance independently and wrap at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x8_reg.sv
// Registered 1-to-2 demultiplexer between the write-back source and the
// two register-file banks. Each destination owns a DEPTH-entry queue so a
// stalled bank never blocks beats headed for the other one.
// Optional feature: define DEMUX_STATS_EN to add per-port 16-bit
// completed-transfer counters (out0_cnt / out1_cnt).
module demux_1x8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [WIDTH-1:0]  out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [WIDTH-1:0]  out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] out0_cnt,
  output logic [STAT_W-1:0] out1_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;
  logic [WIDTH-1:0] head0;
  logic [WIDTH-1:0] head1;
  logic             room0;
  logic             room1;
  logic             push0;
  logic             push1;
  logic             pop0;
  logic             pop1;

  // Readiness depends only on the selected queue's occupancy, never on
  // in_valid and never on the same-cycle pop of that port: a full port
  // refuses the beat even while its consumer is draining.
  assign room0    = (count0 < DEPTH_CNT);
  assign room1    = (count1 < DEPTH_CNT);
  assign in_ready = (in_sel == SEL_PORT1) ? room1 : room0;

  assign push0 = in_valid & in_ready & (in_sel == SEL_PORT0);
  assign push1 = in_valid & in_ready & (in_sel == SEL_PORT1);

  assign out0_valid = (count0 != '0);
  assign out1_valid = (count1 != '0);
  assign out0_data  = head0;
  assign out1_data  = head1;

  assign pop0 = out0_valid & out0_ready;
  assign pop1 = out1_valid & out1_ready;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .head      (head0),
    .count     (count0)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .head      (head1),
    .count     (count1)
  );

`ifdef DEMUX_STATS_EN
  // Count completed pop handshakes per port; wrap from 0xFFFF to 0 is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_cnt <= '0;
      out1_cnt <= '0;
    end else begin
      if (pop0) begin
        out0_cnt <= out0_cnt + STAT_W'(1);
      end
      if (pop1) begin
        out1_cnt <= out1_cnt + STAT_W'(1);
      end
    end
  end
`else
  // Statistics disabled: no counters and no count ports are built.
`endif

endmodule

// File: tb/tb_demux_1x8_reg.sv
// Scoreboard bench for demux_1x8_reg: accepted beats are queued per port,
// a negedge monitor pops and compares on every output handshake.
module tb_demux_1x8_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0]      out0_cnt;
  logic [15:0]      out1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];

  demux_1x8_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .out0_cnt   (out0_cnt),
    .out1_cnt   (out1_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of that port's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL port0_unexpected: got 0x%0h required no beat", out0_data);
        end else begin
          check("port0_data", {24'h0, out0_data}, {24'h0, exp0.pop_front()});
        end
      end
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL port1_unexpected: got 0x%0h required no beat", out1_data);
        end else begin
          check("port1_data", {24'h0, out1_data}, {24'h0, exp1.pop_front()});
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded); called just after a posedge.
  task automatic send(input logic sel, input logic [WIDTH-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) exp1.push_back(d);
        else     exp0.push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat 0x%0h sel %0d got not accepted required accepted", d, sel);
    end
  endtask

  // Wait (bounded) until both queues and both outputs are empty.
  task automatic drain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0 && !out0_valid && !out1_valid) break;
      @(posedge clk);
      #1;
    end
    check({name, "_pending"}, exp0.size() + exp1.size(), 0);
    check({name, "_valid"}, {30'h0, out1_valid, out0_valid}, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_out0_data", out0_data, 0);
    check("rst_out1_data", out1_data, 0);
    in_sel = 1'b0; #1;
    check("rst_in_ready_sel0", in_ready, 1);
    in_sel = 1'b1; #1;
    check("rst_in_ready_sel1", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Steering with one-cycle latency and no bypass
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
    @(negedge clk);
    check("steer0_no_bypass", out0_valid, 0);
    check("steer0_in_ready", in_ready, 1);
    exp0.push_back(8'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("steer0_valid", out0_valid, 1);
    check("steer0_data", out0_data, 8'hA5);
    check("steer0_other_idle", out1_valid, 0);
    @(posedge clk); #1;
    check("steer0_one_cycle", out0_valid, 0);
    send(1'b1, 8'h3C);
    check("steer1_valid", out1_valid, 1);
    check("steer1_data", out1_data, 8'h3C);
    check("steer1_other_idle", out0_valid, 0);
    @(posedge clk); #1;
    check("steer1_one_cycle", out1_valid, 0);
    drain("steer");

    // Backpressure on port 0, port 1 unaffected
    out0_ready = 1'b0;
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    send(1'b1, 8'h77);
    check("bp_head_stable", out0_data, 8'h01);
    out0_ready = 1'b1;
    send(1'b0, 8'h03);
    drain("bp");

    // Full port with pop in the same cycle: no push-through
    out0_ready = 1'b0;
    send(1'b0, 8'h41);
    send(1'b0, 8'h42);
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
    @(negedge clk);
    check("full_pop_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_pop_valid", out0_valid, 1);
    check("full_pop_room", in_ready, 1);
    check("full_pop_head", out0_data, 8'h42);
    drain("full_pop");

    // Pointer wrap: ten back-to-back beats to port 1, consumer toggling
    out1_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(1'b1, 8'h10 + 8'(i));
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out1_ready = ~out1_ready;
        end
      end
    join
    out1_ready = 1'b1;
    drain("wrap");

    // Reset mid-stream discards queued beats
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 8'h66);
    send(1'b1, 8'h99);
    #2;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    check("mid_rst_out0_valid", out0_valid, 0);
    check("mid_rst_out1_valid", out1_valid, 0);
    check("mid_rst_out0_data", out0_data, 0);
    check("mid_rst_out1_data", out1_data, 0);
    in_sel = 1'b0; #1;
    check("mid_rst_in_ready_sel0", in_ready, 1);
    in_sel = 1'b1; #1;
    check("mid_rst_in_ready_sel1", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 8'hC3);
    drain("post_rst");

`ifdef DEMUX_STATS_EN
    // Stats: 0x10000 pops on port 0 since reset wrap its counter to zero
    check("stats_out0_one", out0_cnt, 16'h0001);
    check("stats_out1_zero", out1_cnt, 16'h0000);
    send(1'b1, 8'hE1);
    for (int i = 0; i < 65535; i++) send(1'b0, 8'(i));
    drain("stats");
    check("stats_out0_wrap", out0_cnt, 16'h0000);
    check("stats_out1_hold", out1_cnt, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
